// File: rtl/rdmap_log2_framer.sv
// Range-Doppler magnitude to fixed-point log2 converter and frame wrapper.
// Frames leave as header, frame count, log2 words and a tail marker through an FWFT FIFO.
module rdmap_log2_framer #(
  parameter int unsigned IN_W       = 64,
  parameter int unsigned FRAC_BITS  = 8,
  parameter int unsigned DROP_LSB   = 2,
  parameter int unsigned OUT_W      = 32,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter logic [31:0] TAIL_WORD  = 32'h3A5A3A5A
) (
  input  logic             clk_160mhz,
  input  logic             rst,
  input  logic             fir_enable,
  input  logic [15:0]      horizontal_pitch,
  input  logic             amp_tvalid,
  input  logic [IN_W-1:0]  amp_tdata,
  input  logic             amp_tlast,
  output logic             amp_tready,
  input  logic             fir_tvalid,
  input  logic [IN_W-1:0]  fir_tdata,
  input  logic             fir_tlast,
  output logic             fir_tready,
  output logic             m_tvalid,
  output logic [OUT_W-1:0] m_tdata,
  output logic             m_tlast,
  input  logic             m_tready,
  output logic [31:0]      frame_cnt
);
  localparam int unsigned PIPE_LAT = 3;
  localparam int unsigned EW       = $clog2(IN_W);
  localparam int unsigned RW       = EW + FRAC_BITS + 1;
  localparam int unsigned AW       = $clog2(FIFO_DEPTH);
  localparam int unsigned CNTW     = AW + 1;
  localparam int unsigned PW       = (IN_W > OUT_W) ? IN_W : OUT_W;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_HDR  = 3'd1;
  localparam logic [2:0] ST_CNT  = 3'd2;
  localparam logic [2:0] ST_DATA = 3'd3;
  localparam logic [2:0] ST_TAIL = 3'd4;

  // Mantissa correction table, evaluated once at elaboration.
  function automatic logic [16*FRAC_BITS-1:0] build_corr();
    logic [16*FRAC_BITS-1:0] t;
    real f, v;
    t = '0;
    for (int k = 0; k < 16; k++) begin
      f = (real'(k) + 0.5) / 16.0;
      v = ($ln(1.0 + f) / $ln(2.0) - f) * real'(1 << FRAC_BITS);
      t[k*FRAC_BITS +: FRAC_BITS] = FRAC_BITS'($rtoi(v + 0.5));
    end
    return t;
  endfunction

  localparam logic [16*FRAC_BITS-1:0] CORR_TBL  = build_corr();
  localparam logic [RW-1:0]           DROP_MASK = ~((RW'(1) << DROP_LSB) - RW'(1));

  logic             fir_s1_q, fir_s1_d, fir_s2_q, fir_s2_d;
  logic [15:0]      pitch_s1_q, pitch_s1_d, pitch_s2_q, pitch_s2_d;
  logic [2:0]       state_q, state_d;
  logic             sel_q, sel_d;
  logic [15:0]      pitch_lat_q, pitch_lat_d;
  logic [31:0]      frame_cnt_q, frame_cnt_d;
  logic             s1_vld_q, s1_vld_d, s1_byp_q, s1_byp_d, s1_last_q, s1_last_d;
  logic [PW-1:0]    s1_pay_q, s1_pay_d;
  logic             s2_vld_q, s2_vld_d, s2_byp_q, s2_byp_d, s2_last_q, s2_last_d;
  logic             s2_zero_q, s2_zero_d;
  logic [EW-1:0]    s2_e_q, s2_e_d;
  logic [FRAC_BITS-1:0] s2_m_q, s2_m_d;
  logic [OUT_W-1:0] s2_pay_q, s2_pay_d;
  logic             s3_vld_q, s3_vld_d, s3_last_q, s3_last_d;
  logic [OUT_W-1:0] s3_word_q, s3_word_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNTW-1:0]  count_q, count_d;
  logic [OUT_W:0]   mem_q [FIFO_DEPTH];

  logic             room, in_data, src_valid, src_last, idle_valid, push, pop;
  logic [IN_W-1:0]  src_data, norm;
  logic [EW-1:0]    lod_e;
  logic [3:0]       corr_k;
  logic [FRAC_BITS-1:0] corr;
  logic [RW-1:0]    log_r;
  logic [OUT_W:0]   rd_word;

  assign room       = (CNTW'(FIFO_DEPTH) - count_q) >= CNTW'(PIPE_LAT + 2);
  assign in_data    = (state_q == ST_DATA) && room;
  assign amp_tready = in_data && !sel_q;
  assign fir_tready = in_data && sel_q;
  assign src_valid  = sel_q ? fir_tvalid : amp_tvalid;
  assign src_data   = sel_q ? fir_tdata  : amp_tdata;
  assign src_last   = sel_q ? fir_tlast  : amp_tlast;
  assign idle_valid = fir_s2_q ? fir_tvalid : amp_tvalid;
  assign push       = s3_vld_q;
  assign pop        = m_tvalid && m_tready;

  assign rd_word    = mem_q[rd_ptr_q];
  assign m_tvalid   = (count_q != '0);
  assign m_tdata    = m_tvalid ? rd_word[OUT_W-1:0] : '0;
  assign m_tlast    = m_tvalid && rd_word[OUT_W];
  assign frame_cnt  = frame_cnt_q;

  always_comb begin
    fir_s1_d    = fir_enable;
    fir_s2_d    = fir_s1_q;
    pitch_s1_d  = horizontal_pitch;
    pitch_s2_d  = pitch_s1_q;
    state_d     = state_q;
    sel_d       = sel_q;
    pitch_lat_d = pitch_lat_q;
    frame_cnt_d = frame_cnt_q;
    s1_vld_d    = 1'b0;
    s1_byp_d    = 1'b1;
    s1_last_d   = 1'b0;
    s1_pay_d    = '0;

    // Input FSM: at most one word enters the pipeline per cycle.
    case (state_q)
      ST_IDLE: if (idle_valid && room) begin
        state_d     = ST_HDR;
        sel_d       = fir_s2_q;
        pitch_lat_d = pitch_s2_q;
        frame_cnt_d = frame_cnt_q + 32'd1;
      end
      ST_HDR: if (room) begin
        s1_vld_d = 1'b1;
        s1_pay_d = PW'({16'hFFFF, pitch_lat_q});
        state_d  = ST_CNT;
      end
      ST_CNT: if (room) begin
        s1_vld_d = 1'b1;
        s1_pay_d = PW'(frame_cnt_q);
        state_d  = ST_DATA;
      end
      ST_DATA: if (in_data && src_valid) begin
        s1_vld_d = 1'b1;
        s1_byp_d = 1'b0;
        s1_pay_d = PW'(src_data);
        if (src_last) state_d = ST_TAIL;
      end
      ST_TAIL: if (room) begin
        s1_vld_d  = 1'b1;
        s1_last_d = 1'b1;
        s1_pay_d  = PW'(TAIL_WORD);
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Leading-one detect and normalisation of the sample in stage 1.
    lod_e = '0;
    for (int i = 0; i < IN_W; i++) begin
      if (s1_pay_q[i]) lod_e = EW'(i);
    end
    norm      = s1_pay_q[IN_W-1:0] << (EW'(IN_W - 1) - lod_e);
    s2_vld_d  = s1_vld_q;
    s2_byp_d  = s1_byp_q;
    s2_last_d = s1_last_q;
    s2_zero_d = ~|s1_pay_q[IN_W-1:0];
    s2_e_d    = lod_e;
    s2_m_d    = FRAC_BITS'(norm >> (IN_W - 1 - FRAC_BITS));
    s2_pay_d  = s1_pay_q[OUT_W-1:0];

    corr_k    = s2_m_q[FRAC_BITS-1 -: 4];
    corr      = CORR_TBL[corr_k*FRAC_BITS +: FRAC_BITS];
    log_r     = RW'({s2_e_q, {FRAC_BITS{1'b0}}}) + RW'(s2_m_q) + RW'(corr);
    s3_vld_d  = s2_vld_q;
    s3_last_d = s2_last_q;
    s3_word_d = s2_byp_q  ? s2_pay_q :
                s2_zero_q ? '0 : OUT_W'(log_r & DROP_MASK);

    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CNTW'(1);
      2'b01:   count_d = count_q - CNTW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_160mhz or posedge rst) begin
    if (rst) begin
      fir_s1_q <= 1'b0;  fir_s2_q <= 1'b0;
      pitch_s1_q <= '0;  pitch_s2_q <= '0;
      state_q <= ST_IDLE;  sel_q <= 1'b0;
      pitch_lat_q <= '0;  frame_cnt_q <= '0;
      s1_vld_q <= 1'b0;  s1_byp_q <= 1'b0;  s1_last_q <= 1'b0;  s1_pay_q <= '0;
      s2_vld_q <= 1'b0;  s2_byp_q <= 1'b0;  s2_last_q <= 1'b0;  s2_zero_q <= 1'b0;
      s2_e_q <= '0;  s2_m_q <= '0;  s2_pay_q <= '0;
      s3_vld_q <= 1'b0;  s3_last_q <= 1'b0;  s3_word_q <= '0;
      wr_ptr_q <= '0;  rd_ptr_q <= '0;  count_q <= '0;
    end else begin
      fir_s1_q <= fir_s1_d;  fir_s2_q <= fir_s2_d;
      pitch_s1_q <= pitch_s1_d;  pitch_s2_q <= pitch_s2_d;
      state_q <= state_d;  sel_q <= sel_d;
      pitch_lat_q <= pitch_lat_d;  frame_cnt_q <= frame_cnt_d;
      s1_vld_q <= s1_vld_d;  s1_byp_q <= s1_byp_d;  s1_last_q <= s1_last_d;  s1_pay_q <= s1_pay_d;
      s2_vld_q <= s2_vld_d;  s2_byp_q <= s2_byp_d;  s2_last_q <= s2_last_d;  s2_zero_q <= s2_zero_d;
      s2_e_q <= s2_e_d;  s2_m_q <= s2_m_d;  s2_pay_q <= s2_pay_d;
      s3_vld_q <= s3_vld_d;  s3_last_q <= s3_last_d;  s3_word_q <= s3_word_d;
      wr_ptr_q <= wr_ptr_d;  rd_ptr_q <= rd_ptr_d;  count_q <= count_d;
    end
  end

  // FIFO storage needs no reset; emptiness comes from count_q.
  always_ff @(posedge clk_160mhz) begin
    if (push) mem_q[wr_ptr_q] <= {s3_last_q, s3_word_q};
  end
endmodule

// File: tb/tb_rdmap_log2_framer.sv
// Self-checking bench for rdmap_log2_framer against a frame-level reference model.
module tb_rdmap_log2_framer;
  localparam int FRAC = 8;

  logic        clk_160mhz = 1'b0;
  logic        rst;
  logic        fir_enable;
  logic [15:0] horizontal_pitch;
  logic        amp_tvalid, amp_tlast, amp_tready;
  logic [63:0] amp_tdata;
  logic        fir_tvalid, fir_tlast, fir_tready;
  logic [63:0] fir_tdata;
  logic        m_tvalid, m_tlast, m_tready;
  logic [31:0] m_tdata;
  logic [31:0] frame_cnt;

  logic [32:0] got_q[$];
  logic [32:0] exp_q[$];
  int unsigned model_frames;
  int pass_cnt, total_cnt;
  bit watch_amp, watch_fir;
  int amp_hits, fir_hits;

  always #3 clk_160mhz = ~clk_160mhz;

  rdmap_log2_framer dut (
    .clk_160mhz(clk_160mhz), .rst(rst), .fir_enable(fir_enable),
    .horizontal_pitch(horizontal_pitch),
    .amp_tvalid(amp_tvalid), .amp_tdata(amp_tdata), .amp_tlast(amp_tlast), .amp_tready(amp_tready),
    .fir_tvalid(fir_tvalid), .fir_tdata(fir_tdata), .fir_tlast(fir_tlast), .fir_tready(fir_tready),
    .m_tvalid(m_tvalid), .m_tdata(m_tdata), .m_tlast(m_tlast), .m_tready(m_tready),
    .frame_cnt(frame_cnt)
  );

  always @(negedge clk_160mhz) begin
    if (!rst && m_tvalid && m_tready) got_q.push_back({m_tlast, m_tdata});
    if (watch_fir && fir_tready) fir_hits++;
    if (watch_amp && amp_tready) amp_hits++;
  end

  initial begin
    #400us;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // log2 from its definition: integer exponent, fractional bits, table correction.
  function automatic logic [31:0] ref_log(input logic [63:0] x);
    int e, m, k, corr;
    logic [127:0] frac;
    real f;
    if (x == 64'd0) return 32'd0;
    e = 63;
    while (x < (64'd1 << e)) e--;
    frac = ((128'(x) - (128'd1 << e)) << FRAC) >> e;
    m = int'(frac);
    k = m / (1 << (FRAC - 4));
    f = (real'(k) + 0.5) / 16.0;
    corr = $rtoi(($ln(1.0 + f) / $ln(2.0) - f) * real'(1 << FRAC) + 0.5);
    return 32'(e * (1 << FRAC) + m + corr) & ~32'h3;
  endfunction

  function automatic void model_frame(input logic [15:0] pitch, input logic [63:0] s[$]);
    model_frames++;
    exp_q.push_back({1'b0, 16'hFFFF, pitch});
    exp_q.push_back({1'b0, 32'(model_frames)});
    foreach (s[i]) exp_q.push_back({1'b0, ref_log(s[i])});
    exp_q.push_back({1'b1, 32'h3A5A3A5A});
  endfunction

  function automatic logic [63:0] rnd_sample();
    logic [63:0] v;
    v = {$urandom, $urandom};
    if ($urandom_range(0, 7) == 0) return 64'd0;
    return v >> $urandom_range(0, 63);
  endfunction

  task automatic drive_beat(input bit fir, input logic [63:0] d, input bit last, output bit ok);
    int n;
    n = 0;
    @(posedge clk_160mhz); #1;
    if (fir) begin fir_tvalid = 1'b1; fir_tdata = d; fir_tlast = last; end
    else     begin amp_tvalid = 1'b1; amp_tdata = d; amp_tlast = last; end
    do begin
      @(negedge clk_160mhz); n++;
    end while (!(fir ? fir_tready : amp_tready) && n < 600);
    ok = fir ? fir_tready : amp_tready;
  endtask

  task automatic send_frame(input bit fir, input logic [15:0] pitch, input logic [63:0] s[$], output bit ok);
    bit b;
    ok = 1'b1;
    @(posedge clk_160mhz); #1;
    fir_enable = fir;
    horizontal_pitch = pitch;
    repeat (3) @(posedge clk_160mhz);
    foreach (s[i]) begin
      drive_beat(fir, s[i], i == s.size() - 1, b);
      ok &= b;
    end
    @(posedge clk_160mhz); #1;
    if (fir) begin fir_tvalid = 1'b0; fir_tlast = 1'b0; end
    else     begin amp_tvalid = 1'b0; amp_tlast = 1'b0; end
    model_frame(pitch, s);
  endtask

  task automatic wait_words(input int n, output bit ok);
    int c;
    c = 0;
    while (got_q.size() < n && c < 3000) begin
      @(negedge clk_160mhz); c++;
    end
    repeat (8) @(negedge clk_160mhz);
    ok = (got_q.size() == n);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    #20;
    total_cnt++; if (m_tvalid !== 1'b0) $display("FAIL reset_tvalid got=%b want=0", m_tvalid); else pass_cnt++;
    total_cnt++; if (m_tdata !== 32'd0) $display("FAIL reset_tdata got=%h want=0", m_tdata); else pass_cnt++;
    total_cnt++; if ({amp_tready, fir_tready, m_tlast} !== 3'b000)
      $display("FAIL reset_ready got=%b want=000", {amp_tready, fir_tready, m_tlast}); else pass_cnt++;
    total_cnt++; if (frame_cnt !== 32'd0) $display("FAIL reset_frame_cnt got=%0d want=0", frame_cnt); else pass_cnt++;
    @(posedge clk_160mhz); #1 rst = 1'b0;
  endtask

  task automatic test_known_frame;
    logic [63:0] s[$];
    logic [32:0] want [7];
    bit ok, wok;
    want = '{33'h0FFFF0123, 33'h000000001, 33'h000000000, 33'h000000800,
             33'h000000194, 33'h000000000, 33'h13A5A3A5A};
    s = '{64'd1, 64'd256, 64'd3, 64'd0};
    send_frame(1'b0, 16'h0123, s, ok);
    wait_words(7, wok);
    total_cnt++; if (!(ok && wok)) $display("FAIL known_count got=%0d words want=7", got_q.size()); else pass_cnt++;
    for (int i = 0; i < 7; i++) begin
      total_cnt++;
      if (got_q[i] !== want[i]) $display("FAIL known_word[%0d] got=%h want=%h", i, got_q[i], want[i]);
      else pass_cnt++;
    end
    total_cnt++; if (frame_cnt !== 32'd1) $display("FAIL known_frame_cnt got=%0d want=1", frame_cnt); else pass_cnt++;
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_back_to_back;
    logic [63:0] s[$];
    bit ok, b, wok;
    ok = 1'b1;
    s = '{64'd1, 64'd256, 64'd3, 64'd0};
    send_frame(1'b0, 16'h0123, s, b); ok &= b;
    for (int f = 0; f < 2; f++) begin
      s.delete();
      repeat ($urandom_range(2, 6)) s.push_back(rnd_sample());
      send_frame(1'b0, 16'(16'h0200 + f), s, b); ok &= b;
    end
    wait_words(exp_q.size(), wok);
    total_cnt++; if (!(ok && wok)) $display("FAIL b2b_count got=%0d words want=%0d", got_q.size(), exp_q.size()); else pass_cnt++;
    total_cnt++; if (got_q[1] !== 33'd2) $display("FAIL b2b_second_cnt got=%h want=2", got_q[1]); else pass_cnt++;
    for (int i = 0; i < exp_q.size(); i++) begin
      total_cnt++;
      if (got_q[i] !== exp_q[i]) $display("FAIL b2b_word[%0d] got=%h want=%h", i, got_q[i], exp_q[i]);
      else pass_cnt++;
    end
    total_cnt++; if (frame_cnt !== 32'd4) $display("FAIL b2b_frame_cnt got=%0d want=4", frame_cnt); else pass_cnt++;
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_log_corners;
    logic [63:0] s[$];
    bit ok, wok;
    s = '{64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'd255,
          64'h0000_0000_0001_0000, 64'h0000_0000_0000_00FF};
    repeat (4) s.push_back(rnd_sample());
    send_frame(1'b0, 16'hC0DE, s, ok);
    wait_words(exp_q.size(), wok);
    total_cnt++; if (!(ok && wok)) $display("FAIL log_count got=%0d words want=%0d", got_q.size(), exp_q.size()); else pass_cnt++;
    total_cnt++; if (got_q[2] !== 33'h000003F00) $display("FAIL log_2pow63 got=%h want=3f00", got_q[2]); else pass_cnt++;
    for (int i = 0; i < exp_q.size(); i++) begin
      total_cnt++;
      if (got_q[i] !== exp_q[i]) $display("FAIL log_word[%0d] got=%h want=%h", i, got_q[i], exp_q[i]);
      else pass_cnt++;
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_single_sample;
    logic [63:0] s[$];
    bit ok, wok;
    s = '{rnd_sample()};
    send_frame(1'b0, 16'h0001, s, ok);
    wait_words(4, wok);
    total_cnt++; if (!(ok && wok)) $display("FAIL single_count got=%0d words want=4", got_q.size()); else pass_cnt++;
    for (int i = 0; i < 4; i++) begin
      total_cnt++;
      if (got_q[i] !== exp_q[i]) $display("FAIL single_word[%0d] got=%h want=%h", i, got_q[i], exp_q[i]);
      else pass_cnt++;
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_backpressure;
    logic [63:0] s[$];
    bit ok, wok, low_seen;
    int acc;
    acc = 0; low_seen = 1'b0;
    repeat (32) s.push_back(rnd_sample());
    fork
      send_frame(1'b0, 16'h0BAD, s, ok);
      begin
        @(posedge clk_160mhz); #1 m_tready = 1'b0;
        repeat (40) begin
          @(negedge clk_160mhz);
          if (amp_tvalid && amp_tready) acc++;
          if (amp_tvalid && !amp_tready && acc > 0) low_seen = 1'b1;
        end
        total_cnt++; if (got_q.size() != 0 || !m_tvalid)
          $display("FAIL bp_stall_out got=%0d words valid=%b want=0 words valid=1", got_q.size(), m_tvalid); else pass_cnt++;
        @(posedge clk_160mhz); #1 m_tready = 1'b1;
      end
    join
    total_cnt++; if (!low_seen) $display("FAIL bp_ready_drop got=never want=low while stalled"); else pass_cnt++;
    total_cnt++; if (acc < 8 || acc > 14) $display("FAIL bp_accepted got=%0d want=8..14", acc); else pass_cnt++;
    wait_words(exp_q.size(), wok);
    total_cnt++; if (!(ok && wok)) $display("FAIL bp_count got=%0d words want=%0d", got_q.size(), exp_q.size()); else pass_cnt++;
    for (int i = 0; i < exp_q.size(); i++) begin
      total_cnt++;
      if (got_q[i] !== exp_q[i]) $display("FAIL bp_word[%0d] got=%h want=%h", i, got_q[i], exp_q[i]);
      else pass_cnt++;
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_src_switch;
    logic [63:0] s[$], f[$];
    bit ok, b, wok;
    ok = 1'b1;
    repeat (8) s.push_back(rnd_sample());
    repeat (5) f.push_back(rnd_sample());
    @(posedge clk_160mhz); #1;
    fir_enable = 1'b0; horizontal_pitch = 16'h5A01;
    repeat (3) @(posedge clk_160mhz);
    fir_hits = 0; watch_fir = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (i == 3) begin fir_enable = 1'b1; fir_tvalid = 1'b1; fir_tdata = rnd_sample(); fir_tlast = 1'b0; end
      if (i == 7) fir_tvalid = 1'b0;
      drive_beat(1'b0, s[i], i == 7, b); ok &= b;
    end
    @(posedge clk_160mhz); #1 amp_tvalid = 1'b0; amp_tlast = 1'b0;
    model_frame(16'h5A01, s);
    repeat (4) @(negedge clk_160mhz);
    watch_fir = 1'b0;
    amp_hits = 0; watch_amp = 1'b1;
    send_frame(1'b1, 16'h5A02, f, b); ok &= b;
    wait_words(exp_q.size(), wok);
    watch_amp = 1'b0;
    total_cnt++; if (fir_hits != 0) $display("FAIL switch_fir_ready got=%0d cycles want=0", fir_hits); else pass_cnt++;
    total_cnt++; if (amp_hits != 0) $display("FAIL switch_amp_ready got=%0d cycles want=0", amp_hits); else pass_cnt++;
    total_cnt++; if (!(ok && wok)) $display("FAIL switch_count got=%0d words want=%0d", got_q.size(), exp_q.size()); else pass_cnt++;
    for (int i = 0; i < exp_q.size(); i++) begin
      total_cnt++;
      if (got_q[i] !== exp_q[i]) $display("FAIL switch_word[%0d] got=%h want=%h", i, got_q[i], exp_q[i]);
      else pass_cnt++;
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_random;
    logic [63:0] s[$];
    bit ok, b, wok, done;
    ok = 1'b1; done = 1'b0;
    fork
      begin
        for (int fr = 0; fr < 4; fr++) begin
          s.delete();
          repeat ($urandom_range(1, 10)) s.push_back(rnd_sample());
          send_frame(1'($urandom_range(0, 1)), 16'($urandom), s, b); ok &= b;
        end
        done = 1'b1;
      end
      while (!done) begin
        @(posedge clk_160mhz); #1 m_tready = 1'($urandom_range(0, 1));
      end
    join
    @(posedge clk_160mhz); #1 m_tready = 1'b1;
    wait_words(exp_q.size(), wok);
    total_cnt++; if (!(ok && wok)) $display("FAIL rand_count got=%0d words want=%0d", got_q.size(), exp_q.size()); else pass_cnt++;
    for (int i = 0; i < exp_q.size(); i++) begin
      total_cnt++;
      if (got_q[i] !== exp_q[i]) $display("FAIL rand_word[%0d] got=%h want=%h", i, got_q[i], exp_q[i]);
      else pass_cnt++;
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_rst_mid_frame;
    logic [63:0] s[$];
    bit ok, b, wok;
    @(posedge clk_160mhz); #1;
    fir_enable = 1'b0; horizontal_pitch = 16'h0777;
    repeat (3) @(posedge clk_160mhz);
    for (int i = 0; i < 5; i++) drive_beat(1'b0, rnd_sample(), 1'b0, b);
    @(posedge clk_160mhz); #2 rst = 1'b1;
    #1;
    total_cnt++; if ({m_tvalid, m_tlast, amp_tready, fir_tready} !== 4'b0000)
      $display("FAIL rst_mid_ctrl got=%b want=0000", {m_tvalid, m_tlast, amp_tready, fir_tready}); else pass_cnt++;
    total_cnt++; if ({m_tdata, frame_cnt} !== 64'd0)
      $display("FAIL rst_mid_data got=%h/%0d want=0/0", m_tdata, frame_cnt); else pass_cnt++;
    amp_tvalid = 1'b0;
    got_q.delete(); exp_q.delete(); model_frames = 0;
    repeat (3) @(posedge clk_160mhz);
    #1 rst = 1'b0;
    s = '{rnd_sample(), rnd_sample(), rnd_sample()};
    send_frame(1'b0, 16'h0778, s, ok);
    wait_words(exp_q.size(), wok);
    total_cnt++; if (!(ok && wok)) $display("FAIL rst_after_count got=%0d words want=%0d", got_q.size(), exp_q.size()); else pass_cnt++;
    total_cnt++; if (got_q[1] !== 33'd1) $display("FAIL rst_after_cnt got=%h want=1", got_q[1]); else pass_cnt++;
    for (int i = 0; i < exp_q.size(); i++) begin
      total_cnt++;
      if (got_q[i] !== exp_q[i]) $display("FAIL rst_after_word[%0d] got=%h want=%h", i, got_q[i], exp_q[i]);
      else pass_cnt++;
    end
  endtask

  initial begin
    pass_cnt = 0; total_cnt = 0; model_frames = 0;
    watch_amp = 1'b0; watch_fir = 1'b0; amp_hits = 0; fir_hits = 0;
    rst = 1'b1; fir_enable = 1'b0; horizontal_pitch = '0;
    amp_tvalid = 1'b0; amp_tdata = '0; amp_tlast = 1'b0;
    fir_tvalid = 1'b0; fir_tdata = '0; fir_tlast = 1'b0;
    m_tready = 1'b1;
    test_reset;
    test_known_frame;
    test_back_to_back;
    test_log_corners;
    test_single_sample;
    test_backpressure;
    test_src_switch;
    test_random;
    test_rst_mid_frame;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
